softmax_argmax_stream: RTL and testbench

Streaming classifier stage placed directly downstream of the 2-layer softmax network. Consumes per-sample class scores (softmax or dense-2 outputs, Q-format fixed point) one score per beat over a valid/ready stream. Reduces each group of OUT_SIZE scores to the winning class index plus its score. Buffers results in a small FIFO so the producer is not stalled by a slow consumer, such as the result writer or host readback.

---
 rtl/nn_pkg.sv | 23 ++
 rtl/softmax_argmax_stream_if.sv | 28 ++
 rtl/nn_sync_fifo.sv | 59 +++++
 rtl/softmax_argmax_stream.sv | 96 +++++++++
 tb/tb_softmax_argmax_stream.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nn_pkg.sv
// Shared types for the softmax network and its downstream classifier stages.
package nn_pkg;

   // Class-index width for n classes; never narrower than one bit.
   function automatic int nn_idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int NN_WIDTH    = 18;  // signed score width
   localparam int NN_FRAC     = 8;   // fractional bits (Q-format, informational)
   localparam int NN_OUT_SIZE = 3;   // classes per sample
   localparam int NN_IDX_W    = nn_idx_w(NN_OUT_SIZE);

   typedef logic signed [NN_WIDTH-1:0] score_t;
   typedef logic        [NN_IDX_W-1:0] idx_t;

   // One classification result: winning class and its score.
   typedef struct packed {
      idx_t   idx;
      score_t score;
   } argmax_result_t;

endpackage

// File: rtl/softmax_argmax_stream_if.sv
// Score-in / result-out valid-ready bundle of the argmax stage.
interface softmax_argmax_stream_if
   import nn_pkg::*;
#(
   parameter int WIDTH = NN_WIDTH,
   parameter int IDX_W = NN_IDX_W
);
   logic                    s_valid;
   logic                    s_ready;
   logic signed [WIDTH-1:0] s_data;
   logic                    s_last;
   logic                    m_valid;
   logic                    m_ready;
   logic [IDX_W-1:0]        m_class;
   logic signed [WIDTH-1:0] m_score;

   // Block side: consumes scores, produces results.
   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, m_class, m_score
   );

   // Environment side: producer of scores and consumer of results.
   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, m_class, m_score
   );
endinterface

// File: rtl/nn_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter driving full/empty.
module nn_sync_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_pop,
   output logic [DATA_W-1:0] o_data,
   output logic              o_full,
   output logic              o_empty,
   output logic [CNT_W-1:0]  o_count
);
   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   // Storage write.
   // NOTE: the data array has no reset; validity is tracked by the counter, so stale entries are never observed.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         // NOTE: non-blocking assignments for all sequential state so every register samples pre-edge values.
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   // Head reads as zero while empty so the result outputs have a defined reset value.
   assign o_data  = o_empty ? '0 : r_mem[r_rd_ptr];
endmodule

// File: rtl/softmax_argmax_stream.sv
// Streaming argmax: reduces each OUT_SIZE-score group to {class, score}
// and queues the result in a small FIFO for a slow consumer.
module softmax_argmax_stream
   import nn_pkg::*;
#(
   parameter int WIDTH      = NN_WIDTH,
   parameter int FRAC       = NN_FRAC,
   parameter int OUT_SIZE   = NN_OUT_SIZE,
   parameter int FIFO_DEPTH = 4,
   localparam int IDX_W     = nn_idx_w(OUT_SIZE),
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   softmax_argmax_stream_if.slave   bus,
   output logic [31:0]              sample_cnt,
   output logic                     err_frame
);
   // The result record layout is fixed by nn_pkg; reject configurations it cannot hold.
   if (OUT_SIZE < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       WIDTH != NN_WIDTH || IDX_W != NN_IDX_W || FRAC >= WIDTH) begin : g_bad_param
      $error("softmax_argmax_stream: unsupported parameter set");
   end

   logic [IDX_W-1:0] r_elem_cnt;
   idx_t             r_run_idx;
   score_t           r_run_max;
   logic [31:0]      r_sample_cnt;
   logic             r_err_frame;

   logic             w_accept;
   logic             w_last_elem;
   logic             w_take;
   logic             w_push;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_unused_count;   // occupancy, exposed by the FIFO for debug
   argmax_result_t   w_push_data;
   argmax_result_t   w_head;

   assign w_accept    = bus.s_valid && bus.s_ready;
   assign w_last_elem = (r_elem_cnt == IDX_W'(OUT_SIZE - 1));
   // First element always seeds the running max; later ones must be strictly greater (ties keep lower index).
   assign w_take      = (r_elem_cnt == '0) || (bus.s_data > r_run_max);
   assign w_push      = w_accept && w_last_elem;

   // The final compare is folded in combinationally so the result is pushed with the last beat.
   assign w_push_data.idx   = w_take ? r_elem_cnt : r_run_idx;
   assign w_push_data.score = w_take ? bus.s_data : r_run_max;

   // Running max, element framing, sample counter and sticky framing error.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_elem_cnt   <= '0;
         r_run_idx    <= '0;
         r_run_max    <= '0;
         r_sample_cnt <= '0;
         r_err_frame  <= 1'b0;
      end else if (w_accept) begin
         if (w_take) begin
            r_run_max <= bus.s_data;
            r_run_idx <= r_elem_cnt;
         end
         if (w_last_elem) begin
            r_elem_cnt   <= '0;
            r_sample_cnt <= r_sample_cnt + 32'd1;
         end else begin
            r_elem_cnt <= r_elem_cnt + IDX_W'(1);
         end
         if (bus.s_last != w_last_elem) r_err_frame <= 1'b1;
      end
   end

   nn_sync_fifo #(
      .DATA_W ($bits(argmax_result_t)),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (bus.m_ready),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_unused_count)
   );

   // s_ready depends only on registered occupancy, never on m_ready.
   assign bus.s_ready = !w_full;
   assign bus.m_valid = !w_empty;
   assign bus.m_class = w_head.idx;
   assign bus.m_score = w_head.score;
   assign sample_cnt  = r_sample_cnt;
   assign err_frame   = r_err_frame;
endmodule

// File: tb/tb_softmax_argmax_stream.sv
// Self-checking bench for softmax_argmax_stream: directed vectors,
// corner-case sequences and a randomized soak against an argmax model.
module tb_softmax_argmax_stream;
   import nn_pkg::*;

   localparam int N = 3;

   typedef struct {
      int s [N];
      int exp_class;
      int exp_score;
   } vec_t;

   typedef struct {
      int cls;
      int sc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] sample_cnt;
   logic        err_frame;

   int   n_checks = 0;
   int   n_errors = 0;
   int   exp_cnt  = 0;
   exp_t exp_q[$];
   vec_t vecs[7];

   softmax_argmax_stream_if #(.WIDTH(18), .IDX_W(2)) bus();

   softmax_argmax_stream #(.FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .sample_cnt (sample_cnt),
      .err_frame  (err_frame)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Winning class: highest score, lowest index on ties.
   task automatic ref_argmax(input int a [N], output int cls, output int sc);
      cls = 0;
      sc  = a[0];
      for (int k = 1; k < N; k++) begin
         if (a[k] > sc) begin
            cls = k;
            sc  = a[k];
         end
      end
   endtask

   task automatic set_vec(input int i, input int a0, input int a1, input int a2, input int cls, input int sc);
      vecs[i].s[0]      = a0;
      vecs[i].s[1]      = a1;
      vecs[i].s[2]      = a2;
      vecs[i].exp_class = cls;
      vecs[i].exp_score = sc;
   endtask

   // Present one beat and hold it until accepted; returns #1 after the accepting edge.
   task automatic send_beat(input int d, input bit last);
      int waited = 0;
      bus.s_valid = 1'b1;
      bus.s_data  = score_t'(d);
      bus.s_last  = last;
      while (!bus.s_ready && waited < 200) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!bus.s_ready) check("beat_accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.s_valid = 1'b0;
   endtask

   task automatic send_sample(input int a [N], input int gap_max);
      for (int k = 0; k < N; k++) begin
         int gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
         for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
         end
         send_beat(a[k], k == N - 1);
      end
   endtask

   // Pop n results, comparing each against the scoreboard in order.
   task automatic consume(input int n, input bit rand_ready);
      int got = 0;
      int cyc = 0;
      exp_t e;
      while (got < n && cyc < 20000) begin
         bus.m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.m_valid && bus.m_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("stream_class", bus.m_class, e.cls);
               check("stream_score", bus.m_score, e.sc);
            end
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      bus.m_ready = 1'b0;
      if (got < n) check("consume_timeout", got, n);
   endtask

   task automatic pop_one();
      bus.m_ready = 1'b1;
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int a [N];
      int cls, sc;
      exp_t e;

      bus.s_valid = 1'b0;
      bus.s_data  = '0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;

      set_vec(0,    -64,     -64,    -300, 0,    -64);
      set_vec(1,   -300,     -10,     -10, 1,    -10);
      set_vec(2,     10,       5,      20, 2,     20);
      set_vec(3, 131071, -131072,  131071, 0, 131071);
      set_vec(4, -131072, -131072, -131071, 2, -131071);
      set_vec(5,      5,       6,       6, 1,      6);
      set_vec(6,     51,     179,      25, 1,    179);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      check("rst_s_ready", bus.s_ready, 1);
      check("rst_m_valid", bus.m_valid, 0);
      check("rst_m_class", bus.m_class, 0);
      check("rst_m_score", bus.m_score, 0);
      check("rst_sample_cnt", sample_cnt, 0);
      check("rst_err_frame", err_frame, 0);

      // Single sample with consumer ready: result one cycle after last beat, no bypass.
      bus.m_ready = 1'b1;
      send_beat(51, 1'b0);
      send_beat(179, 1'b0);
      check("single_pre_valid", bus.m_valid, 0);
      send_beat(25, 1'b1);
      exp_cnt++;
      check("single_valid", bus.m_valid, 1);
      check("single_class", bus.m_class, 1);
      check("single_score", bus.m_score, 179);
      check("single_sample_cnt", sample_cnt, exp_cnt);
      check("single_err_frame", err_frame, 0);
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      check("single_popped", bus.m_valid, 0);

      // Table-driven vectors, consumer stalled until each result is checked.
      for (int i = 0; i < 7; i++) begin
         check("vec_pre_valid", bus.m_valid, 0);
         send_sample(vecs[i].s, 0);
         exp_cnt++;
         check("vec_valid", bus.m_valid, 1);
         check("vec_class", bus.m_class, vecs[i].exp_class);
         check("vec_score", bus.m_score, vecs[i].exp_score);
         check("vec_sample_cnt", sample_cnt, exp_cnt);
         pop_one();
         check("vec_popped", bus.m_valid, 0);
      end

      // Backpressure: four results fill the FIFO, the fifth sample stalls.
      for (int s = 0; s < 4; s++) begin
         a[0] = 100 * s; a[1] = 100 * s + 7 - 3 * s; a[2] = 100 * s + 3;
         ref_argmax(a, cls, sc);
         e.cls = cls; e.sc = sc;
         exp_q.push_back(e);
         send_sample(a, 0);
      end
      exp_cnt += 4;
      check("bp_full_s_ready", bus.s_ready, 0);
      check("bp_full_cnt", sample_cnt, exp_cnt);
      check("bp_full_valid", bus.m_valid, 1);
      bus.s_valid = 1'b1;
      bus.s_data  = score_t'(-5);
      bus.s_last  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("bp_stalled_s_ready", bus.s_ready, 0);
      check("bp_stalled_cnt", sample_cnt, exp_cnt);
      a[0] = -5; a[1] = -9; a[2] = -2;
      ref_argmax(a, cls, sc);
      e.cls = cls; e.sc = sc;
      exp_q.push_back(e);
      fork
         send_sample(a, 0);
         consume(5, 1'b0);
      join
      exp_cnt++;
      check("bp_drain_cnt", sample_cnt, exp_cnt);
      check("bp_drain_left", exp_q.size(), 0);
      check("bp_drain_valid", bus.m_valid, 0);

      // Framing error: s_last on element 1; result still produced after element 2.
      bus.m_ready = 1'b1;
      check("frame_pre_err", err_frame, 0);
      send_beat(7, 1'b0);
      send_beat(9, 1'b1);
      check("frame_err_set", err_frame, 1);
      send_beat(3, 1'b0);
      exp_cnt++;
      check("frame_valid", bus.m_valid, 1);
      check("frame_class", bus.m_class, 1);
      check("frame_score", bus.m_score, 9);
      @(posedge clk); #1;
      bus.m_ready = 1'b0;
      check("frame_err_sticky", err_frame, 1);
      check("frame_cnt", sample_cnt, exp_cnt);

      // Reset mid-sample discards the partial sample and the sticky flag.
      send_beat(100, 1'b0);
      send_beat(200, 1'b0);
      pulse_reset();
      exp_cnt = 0;
      check("mid_rst_s_ready", bus.s_ready, 1);
      check("mid_rst_m_valid", bus.m_valid, 0);
      check("mid_rst_m_class", bus.m_class, 0);
      check("mid_rst_m_score", bus.m_score, 0);
      check("mid_rst_cnt", sample_cnt, 0);
      check("mid_rst_err", err_frame, 0);
      send_beat(10, 1'b0);
      send_beat(5, 1'b0);
      send_beat(20, 1'b1);
      check("mid_rst_valid", bus.m_valid, 1);
      check("mid_rst_class", bus.m_class, 2);
      check("mid_rst_score", bus.m_score, 20);
      check("mid_rst_one_cnt", sample_cnt, 1);
      pop_one();
      check("mid_rst_only_one", bus.m_valid, 0);

      // Random soak from a clean reset.
      pulse_reset();
      fork
         begin
            int b [N];
            int c, v;
            exp_t x;
            for (int s = 0; s < 300; s++) begin
               for (int k = 0; k < N; k++) begin
                  if ($urandom_range(0, 3) == 0) b[k] = int'(score_t'($urandom));
                  else b[k] = int'($urandom_range(0, 8)) - 4;
               end
               ref_argmax(b, c, v);
               x.cls = c; x.sc = v;
               exp_q.push_back(x);
               send_sample(b, 2);
            end
         end
         consume(300, 1'b1);
      join
      check("soak_sample_cnt", sample_cnt, 300);
      check("soak_err_frame", err_frame, 0);
      check("soak_left", exp_q.size(), 0);
      check("soak_m_valid", bus.m_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
